// File: rtl/tap_mac_pkg.sv
// rtl/tap_mac_pkg.sv - shared widths, fill depth and FSM states for the tap MAC
package tap_mac_pkg;

    localparam int DATA_W     = 8;
    localparam int PROD_W     = 16;
    localparam int SUM_W      = 18;
    localparam int TAP_COUNT  = 4;
    localparam int FILL_DEPTH = 64;
    localparam int CNT_W      = 7;

    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(FILL_DEPTH);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_DEPTH - 1);

    typedef enum logic {
        ST_FILL,
        ST_RUN
    } state_t;

endpackage

// File: rtl/tap_mac_lane.sv
// rtl/tap_mac_lane.sv - one registered unsigned multiply lane (tap * coef when en)
module tap_mac_lane
    import tap_mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] tap,
    input  logic [DATA_W-1:0] coef,
    output logic [PROD_W-1:0] product
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else if (en) begin
            product <= PROD_W'(tap) * PROD_W'(coef);
        end
    end

endmodule

// File: rtl/tap_mac_4x8.sv
// rtl/tap_mac_4x8.sv - weighted sum of four shift-register taps; TAP_MAC_SAT_EN clamps y to CLAMP_MAX
module tap_mac_4x8
    import tap_mac_pkg::*;
#(
    parameter logic [DATA_W-1:0] COEF0     = 8'd1,
    parameter logic [DATA_W-1:0] COEF1     = 8'd1,
    parameter logic [DATA_W-1:0] COEF2     = 8'd1,
    parameter logic [DATA_W-1:0] COEF3     = 8'd1,
    parameter logic [SUM_W-1:0]  CLAMP_MAX = 18'd65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift,
    input  logic              flush,
    input  logic [DATA_W-1:0] sr_tap_one,
    input  logic [DATA_W-1:0] sr_tap_two,
    input  logic [DATA_W-1:0] sr_tap_three,
    input  logic [DATA_W-1:0] sr_out,
    output logic              primed,
    output logic [SUM_W-1:0]  y,
    output logic              y_valid
);

`ifdef TAP_MAC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    // An all-ones ceiling can never bind because the sum tops out below 2^18.
    localparam logic [SUM_W-1:0] CEIL = SAT_EN ? CLAMP_MAX : {SUM_W{1'b1}};

    localparam logic [TAP_COUNT*DATA_W-1:0] COEF_VEC = {COEF3, COEF2, COEF1, COEF0};

    state_t                   state;
    state_t                   state_nx;
    logic [CNT_W-1:0]         fill_cnt;
    logic                     shift_d;
    logic                     s1_valid;
    logic [TAP_COUNT*DATA_W-1:0] tap_vec;
    logic [PROD_W-1:0]        prod [TAP_COUNT];
    logic [SUM_W-1:0]         sum;
    logic [SUM_W-1:0]         y_nx;

    assign primed  = (state == ST_RUN);
    assign tap_vec = {sr_out, sr_tap_three, sr_tap_two, sr_tap_one};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
            shift_d  <= 1'b0;
        end else begin
            state <= state_nx;
            if (flush) begin
                fill_cnt <= '0;
                shift_d  <= 1'b0;
            end else begin
                shift_d <= shift;
                if (shift && fill_cnt != FILL_FULL) begin
                    fill_cnt <= fill_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_FILL: if (!flush && shift && fill_cnt == FILL_LAST) state_nx = ST_RUN;
            ST_RUN:  if (flush) state_nx = ST_FILL;
            default: state_nx = ST_FILL;
        endcase
    end

    // The taps reflect a shift one cycle later, so capture is keyed off shift_d.
    for (genvar g = 0; g < TAP_COUNT; g++) begin : g_lane
        tap_mac_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (shift_d),
            .tap     (tap_vec[g*DATA_W +: DATA_W]),
            .coef    (COEF_VEC[g*DATA_W +: DATA_W]),
            .product (prod[g])
        );
    end

    always_comb begin
        sum  = SUM_W'(prod[0]) + SUM_W'(prod[1]) + SUM_W'(prod[2]) + SUM_W'(prod[3]);
        y_nx = (sum > CEIL) ? CEIL : sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            y_valid  <= 1'b0;
            y        <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            y_valid  <= 1'b0;
        end else begin
            s1_valid <= shift_d & primed;
            y_valid  <= s1_valid;
            if (s1_valid) begin
                y <= y_nx;
            end
        end
    end

endmodule

// File: tb/tb_tap_mac_4x8.sv
// tb/tb_tap_mac_4x8.sv - scoreboard bench for tap_mac_4x8 against an upstream shift-register model
module tb_tap_mac_4x8;

    localparam int CLAMP = 65535;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        shift;
    logic        flush;
    logic [7:0]  t1, t2, t3, t4;
    logic        primed, y_valid, mx_primed, mx_y_valid;
    logic [17:0] y, mx_y;

    typedef struct {
        int due;
        int y;
        int ymax;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] sr [64];
    int         cyc = 0;
    int         m_cnt = 0;
    int         last_y = 0;
    int         last_ymax = 0;
    int         vcnt = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         exp_primed = 1'b0;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tap_mac_4x8 #(
        .COEF0(8'd1), .COEF1(8'd2), .COEF2(8'd3), .COEF3(8'd4), .CLAMP_MAX(18'd65535)
    ) dut (
        .clk(clk), .rst_n(rst_n), .shift(shift), .flush(flush),
        .sr_tap_one(t1), .sr_tap_two(t2), .sr_tap_three(t3), .sr_out(t4),
        .primed(primed), .y(y), .y_valid(y_valid)
    );

    tap_mac_4x8 #(
        .COEF0(8'd255), .COEF1(8'd255), .COEF2(8'd255), .COEF3(8'd255), .CLAMP_MAX(18'd65535)
    ) dut_max (
        .clk(clk), .rst_n(rst_n), .shift(shift), .flush(flush),
        .sr_tap_one(t1), .sr_tap_two(t2), .sr_tap_three(t3), .sr_out(t4),
        .primed(mx_primed), .y(mx_y), .y_valid(mx_y_valid)
    );

    function automatic int sat(input int v);
`ifdef TAP_MAC_SAT_EN
        return (v > CLAMP) ? CLAMP : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    endtask

    // One clock of stimulus; the reference shift register is advanced here and
    // its new stage values reach the DUT taps just after the edge.
    task automatic step(input logic sh, input logic fl, input logic [7:0] din);
        exp_t e;
        exp_t keep[$];
        exp_primed = (m_cnt == 64);
        shift = sh;
        flush = fl;
        if (sh) begin
            for (int i = 63; i > 0; i--) sr[i] = sr[i-1];
            sr[0] = din;
        end
        if (fl) begin
            m_cnt = 0;
            foreach (sb[i]) if (sb[i].due <= cyc) keep.push_back(sb[i]);
            sb = keep;
        end else if (sh) begin
            if (m_cnt < 64) m_cnt++;
            if (m_cnt == 64) begin
                e.due  = cyc + 3;
                e.y    = sat(int'(sr[15]) + 2*int'(sr[31]) + 3*int'(sr[47]) + 4*int'(sr[63]));
                e.ymax = sat(255 * (int'(sr[15]) + int'(sr[31]) + int'(sr[47]) + int'(sr[63])));
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        t1 = sr[15];
        t2 = sr[31];
        t3 = sr[47];
        t4 = sr[63];
    endtask

    task automatic do_reset();
        shift = 1'b0;
        flush = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_primed = 1'b0;
        m_cnt = 0;
        sb.delete();
        last_y = 0;
        last_ymax = 0;
        #1;
        check("rst_y", int'(y), 0);
        check("rst_y_valid", int'(y_valid), 0);
        check("rst_primed", int'(primed), 0);
        check("rst_mx_y", int'(mx_y), 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("primed", int'(primed), int'(exp_primed));
            check("mx_y_valid", int'(mx_y_valid), int'(y_valid));
            if (y_valid) begin
                vcnt++;
                if (sb.size() == 0) begin
                    check("unexpected_y_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency", cyc, e.due);
                    check("y", int'(y), e.y);
                    check("mx_y", int'(mx_y), e.ymax);
                    last_y = e.y;
                    last_ymax = e.ymax;
                end
            end else begin
                check("y_hold", int'(y), last_y);
                check("mx_y_hold", int'(mx_y), last_ymax);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    check("missing_y_valid", 0, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        shift = 1'b0;
        flush = 1'b0;
        t1 = '0; t2 = '0; t3 = '0; t4 = '0;
        foreach (sr[i]) sr[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_y", int'(y), 0);
        check("reset_y_valid", int'(y_valid), 0);
        check("reset_primed", int'(primed), 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Constant fill: first result is 10*(1+2+3+4)
        repeat (64) step(1'b1, 1'b0, 8'd10);
        check("fill10_last_y", last_y, 0);
        repeat (4) step(1'b0, 1'b0, 8'd0);
        check("fill10_y", int'(y), 100);

        // 63 shifts never prime
        step(1'b0, 1'b1, 8'd0);
        repeat (63) step(1'b1, 1'b0, 8'($urandom));
        repeat (10) step(1'b0, 1'b0, 8'd0);
        check("primed_after_63", int'(primed), 0);
        step(1'b1, 1'b0, 8'($urandom));
        repeat (4) step(1'b0, 1'b0, 8'd0);
        check("primed_after_64", int'(primed), 1);

        // Full-scale taps
        repeat (64) step(1'b1, 1'b0, 8'd255);
        repeat (4) step(1'b0, 1'b0, 8'd0);
`ifdef TAP_MAC_SAT_EN
        check("full_scale_mx_y", int'(mx_y), 65535);
`else
        check("full_scale_mx_y", int'(mx_y), 260100);
`endif
        check("full_scale_y", int'(y), 2550);

        // Flush together with a shift while results are in flight
        repeat (20) step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 8'($urandom));
        check("flush_primed", int'(primed), 0);
        repeat (63) step(1'b1, 1'b0, 8'($urandom));
        repeat (3) step(1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'($urandom));
        repeat (4) step(1'b0, 1'b0, 8'd0);

        // Random traffic with occasional flushes
        repeat (500) step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 59) == 0), 8'($urandom));
        repeat (4) step(1'b0, 1'b0, 8'd0);

        // Reset mid-pipeline, then 100 shifts give 37 results
        repeat (66) step(1'b1, 1'b0, 8'($urandom));
        do_reset();
        vcnt = 0;
        repeat (100) step(1'b1, 1'b0, 8'($urandom));
        repeat (5) step(1'b0, 1'b0, 8'd0);
        check("post_reset_valid_count", vcnt, 37);
        check("sb_drained", sb.size(), 0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
